// File: rtl/data_mem_ws_if.sv
// Request/response bus for the wait-state data memory.
// The requester (fetch or LSU) uses the master modport; the memory uses slave.
interface data_mem_ws_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BYTES = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [BYTES-1:0]      req_be;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_ws.sv
// Word-organised data/instruction memory with byte strobes, a fixed number of
// wait states behind a valid/ready request, and an error response for
// misaligned or out-of-range addresses. One request is in flight at a time;
// the response is a single-cycle pulse with no backpressure.
module data_mem_ws #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    data_mem_ws_if.slave  bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
    // One extra bit so MEM_DEPTH*BYTES never wraps when it equals 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic                  we_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BYTES-1:0]      be_q;
    logic                  err_q;
    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic                  resp_err_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  ready;
    logic                  accept;
    logic                  req_err;
    logic                  do_access;
    logic                  mem_we;
    logic                  acc_we;
    logic [IDX_W-1:0]      acc_idx;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [BYTES-1:0]      acc_be;
    logic                  acc_err;

    assign ready  = (state_q == S_IDLE) && reset;
    assign accept = bus.req_valid && ready;

    assign bus.req_ready  = ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    // Classify the incoming address: misaligned or beyond the array is a fault.
    always_comb begin
        req_err = (|(bus.req_addr & ADDR_WIDTH'(BYTES - 1)))
                  || ({1'b0, bus.req_addr} >= ADDR_LIMIT);
    end

    // Pick the operands for the access edge: the live request when there are
    // no wait states (access happens on the accept edge), else the latched copy.
    always_comb begin
        do_access = (ZERO_WAIT && accept)
                    || ((state_q == S_WAIT) && (cnt_q == 4'd1));
        if (state_q == S_IDLE) begin
            acc_we    = bus.req_we;
            acc_idx   = bus.req_addr[LSB +: IDX_W];
            acc_wdata = bus.req_wdata;
            acc_be    = bus.req_be;
            acc_err   = req_err;
        end else begin
            acc_we    = we_q;
            acc_idx   = idx_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
            acc_err   = err_q;
        end
        mem_we = do_access && acc_we && !acc_err;
    end

    // Request FSM with registered response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        we_q    <= bus.req_we;
                        idx_q   <= bus.req_addr[LSB +: IDX_W];
                        wdata_q <= bus.req_wdata;
                        be_q    <= bus.req_be;
                        err_q   <= req_err;
                        if (ZERO_WAIT) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            resp_valid_q <= do_access;
            if (do_access) begin
                resp_err_q   <= acc_err;
                resp_rdata_q <= (acc_err || acc_we) ? '0 : mem[acc_idx];
            end
        end
    end

    // Byte-lane array write on the access edge.
    // NOTE: the array deliberately has no reset: contents must survive reset,
    // and a resettable array would not map onto RAM macros.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < BYTES; k++) begin
                if (acc_be[k]) begin
                    mem[acc_idx][8*k +: 8] <= acc_wdata[8*k +: 8];
                end
            end
        end
    end
endmodule
